// File: rtl/ms_pick_actor_pkg.sv
// Shared constants and helpers for the multi-stream PICK actor.
package ms_pkg;

   // Consumption modes selected by the mode input
   localparam logic MODE_SDF  = 1'b0;
   localparam logic MODE_CSDF = 1'b1;

   // Width of each per-flux completed-cycle counter
   localparam int CYC_W = 8;

   // Bits needed to index n items, never less than one
   function automatic int tag_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ms_pick_actor_if.sv
// Token bus of the PICK actor: input ports with per-queue full flags,
// and a single output port with downstream back-pressure.
interface ms_pick_actor_if #(
   parameter int PORTS = 2,
   parameter int FLUX  = 2,
   parameter int WIDTH = 9
);
   logic [PORTS-1:0]       in_port_write;
   logic [PORTS*WIDTH-1:0] in_port_datain;
   logic [PORTS*FLUX-1:0]  in_port_full;
   logic                   out_port_full;
   logic                   out_port_write;
   logic [WIDTH-1:0]       out_port_dataout;

   // Token producer / consumer side (testbench or upstream/downstream fabric)
   modport master (
      output in_port_write,
      output in_port_datain,
      output out_port_full,
      input  in_port_full,
      input  out_port_write,
      input  out_port_dataout
   );

   // Actor side
   modport slave (
      input  in_port_write,
      input  in_port_datain,
      input  out_port_full,
      output in_port_full,
      output out_port_write,
      output out_port_dataout
   );
endinterface

// File: rtl/ms_pick_actor_fifo.sv
// Single circular token queue: independent read/write pointers,
// occupancy counter 0..DEPTH, head of queue visible without a pop.
module ms_fifo
   import ms_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             empty,
   output logic             full,
   output logic [WIDTH-1:0] head
);
   localparam int PTR_W = tag_width(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             push_ok;
   logic             pop_ok;

   // Flags come straight from the registered count, so they show the
   // occupancy left by the previous edge. A full queue refuses a push
   // even when it is popped in the same cycle.
   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_FULL);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem_reg[rd_ptr_reg];

   // Token storage; contents need no reset because the count gates them
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= din;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/ms_pick_actor.sv
// Multi-stream PICK actor. Tokens are queued per (port, flux); each cycle
// at most one eligible flux fires, chosen round-robin, and emits the token
// selected by that flux's phase counter. SDF consumes one token from every
// port per firing, CSDF consumes only the token at the current phase.
module ms_pick_actor
   import ms_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FLUX       = 2,
   parameter int PORTS      = 2,
   parameter int DEPTH      = 4,
   parameter int TAG_WIDTH  = tag_width(FLUX),
   parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode,
   ms_pick_actor_if.slave        bus,
   output logic [FLUX*CYC_W-1:0] cycles_done
);
   localparam int PH_W = tag_width(PORTS);
   localparam logic [PH_W-1:0]      PH_LAST   = PH_W'(PORTS - 1);
   localparam logic [TAG_WIDTH-1:0] FLUX_LAST = TAG_WIDTH'(FLUX - 1);

   genvar gi, gj;

   // Queue array signals, indexed [port][flux]
   logic             q_push  [PORTS][FLUX];
   logic             q_pop   [PORTS][FLUX];
   logic             q_empty [PORTS][FLUX];
   logic             q_full  [PORTS][FLUX];
   logic [WIDTH-1:0] q_head  [PORTS][FLUX];

   // Control state
   logic [PH_W-1:0]      ph_reg  [FLUX];
   logic [CYC_W-1:0]     cyc_reg [FLUX];
   logic [TAG_WIDTH-1:0] ptr_reg;
   logic                 mode_reg;
   logic                 out_write_reg;
   logic [WIDTH-1:0]     out_data_reg;

   // Firing decision
   logic [FLUX-1:0]      elig;
   logic [TAG_WIDTH-1:0] sel;
   logic [TAG_WIDTH-1:0] cand;
   logic                 found;
   logic                 mode_change;
   logic                 fire;
   logic [WIDTH-1:0]     pick_head;

   assign mode_change = (mode != mode_reg);
   assign fire        = found && !bus.out_port_full && !mode_change;

   // Routing decode, queue instances and per-queue pop strobes
   for (gi = 0; gi < PORTS; gi++) begin : g_port
      logic [TAG_WIDTH-1:0] tag;
      assign tag = bus.in_port_datain[gi*WIDTH+DATA_WIDTH +: TAG_WIDTH];

      for (gj = 0; gj < FLUX; gj++) begin : g_flux
         // Tags outside 0..FLUX-1 match no queue and are dropped here
         assign q_push[gi][gj] = bus.in_port_write[gi] && (tag == TAG_WIDTH'(gj));

         assign q_pop[gi][gj] = fire && (sel == TAG_WIDTH'(gj)) &&
                                ((mode_reg == MODE_SDF) || (ph_reg[gj] == PH_W'(gi)));

         ms_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (q_push[gi][gj]),
            .pop   (q_pop[gi][gj]),
            .din   (bus.in_port_datain[gi*WIDTH +: WIDTH]),
            .empty (q_empty[gi][gj]),
            .full  (q_full[gi][gj]),
            .head  (q_head[gi][gj])
         );

         assign bus.in_port_full[gi*FLUX+gj] = q_full[gi][gj];
      end
   end

   // Eligibility per flux: all ports ready (SDF) or the phase port ready (CSDF)
   for (gj = 0; gj < FLUX; gj++) begin : g_elig
      logic [PORTS-1:0] ne;
      for (gi = 0; gi < PORTS; gi++) begin : g_ne
         assign ne[gi] = !q_empty[gi][gj];
      end
      assign elig[gj] = (mode_reg == MODE_SDF) ? (&ne) : ne[ph_reg[gj]];
   end

   // Round-robin search for the first eligible flux starting at the pointer
   always_comb begin
      sel   = '0;
      found = 1'b0;
      cand  = ptr_reg;
      for (int i = 0; i < FLUX; i++) begin
         if (!found && elig[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
         cand = (cand == FLUX_LAST) ? '0 : cand + 1'b1;
      end
   end

   // Token at the fired flux's phase port; its stored tag already equals
   // the flux index because routing placed it by that tag
   always_comb begin
      pick_head = q_head[ph_reg[sel]][sel];
   end

   // Registered copy of mode for change detection, tracked through reset
   // so a static mode never looks like a change after reset release
   always_ff @(posedge clk) begin
      mode_reg <= mode;
   end

   // Phase counters, cycle counters and arbiter pointer
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int f = 0; f < FLUX; f++) begin
            ph_reg[f]  <= '0;
            cyc_reg[f] <= '0;
         end
         ptr_reg <= '0;
      end else if (mode_change) begin
         for (int f = 0; f < FLUX; f++) begin
            ph_reg[f] <= '0;
         end
      end else if (fire) begin
         if (ph_reg[sel] == PH_LAST) begin
            ph_reg[sel]  <= '0;
            cyc_reg[sel] <= cyc_reg[sel] + 1'b1;
         end else begin
            ph_reg[sel] <= ph_reg[sel] + 1'b1;
         end
         ptr_reg <= (sel == FLUX_LAST) ? '0 : sel + 1'b1;
      end
   end

   // Output register: one-cycle valid pulse per firing, data held between
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_write_reg <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         out_write_reg <= fire;
         if (fire) begin
            out_data_reg <= pick_head;
         end
      end
   end

   assign bus.out_port_write   = out_write_reg;
   assign bus.out_port_dataout = out_data_reg;

   for (gj = 0; gj < FLUX; gj++) begin : g_cyc
      assign cycles_done[gj*CYC_W +: CYC_W] = cyc_reg[gj];
   end

endmodule

// File: tb/tb_ms_pick_actor.sv
// Scoreboard bench for ms_pick_actor (PORTS=2, FLUX=2, DEPTH=4, 9-bit tokens).
module tb_ms_pick_actor;
   localparam int DW = 8;
   localparam int FL = 2;
   localparam int PT = 2;
   localparam int DP = 4;
   localparam int W  = 9;

   logic          clk  = 1'b0;
   logic          rst  = 1'b0;
   logic          mode = 1'b0;
   logic [FL*8-1:0] cycles_done;

   ms_pick_actor_if #(.PORTS(PT), .FLUX(FL), .WIDTH(W)) ifc ();

   ms_pick_actor #(
      .DATA_WIDTH (DW),
      .FLUX       (FL),
      .PORTS      (PT),
      .DEPTH      (DP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mode        (mode),
      .bus         (ifc.slave),
      .cycles_done (cycles_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_exp;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] tok(input logic t, input logic [7:0] d);
      return {t, d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic w0, input logic [W-1:0] d0, input logic w1, input logic [W-1:0] d1);
      ifc.in_port_write  = {w1, w0};
      ifc.in_port_datain = {d1, d0};
      tick();
      ifc.in_port_write  = '0;
   endtask

   task automatic drain(input string tag, input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      tick();
      tick();
      check_val(tag, 32'(exp_q.size()), 32'd0);
   endtask

   // Output monitor: every pulse is matched against the scoreboard head
   always @(negedge clk) begin
      if (rst && ifc.out_port_write) begin
         if (exp_q.size() == 0) begin
            check_val("spurious_write", 32'(ifc.out_port_write), 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            $display("txn out=0x%03h exp=0x%03h", ifc.out_port_dataout, mon_exp);
            check_val("out_data", 32'(ifc.out_port_dataout), 32'(mon_exp));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, %0d outputs still pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      ifc.in_port_write  = '0;
      ifc.in_port_datain = '0;
      ifc.out_port_full  = 1'b0;

      // Reset held for 3 edges with writes active
      ifc.in_port_write  = 2'b11;
      ifc.in_port_datain = {tok(1'b0, 8'hBB), tok(1'b0, 8'hAA)};
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("rst_in_full", 32'(ifc.in_port_full), 32'd0);
         check_val("rst_out_write", 32'(ifc.out_port_write), 32'd0);
         check_val("rst_out_data", 32'(ifc.out_port_dataout), 32'd0);
         check_val("rst_cycles", 32'(cycles_done), 32'd0);
      end
      rst = 1'b1;
      ifc.in_port_write = '0;
      @(negedge clk);
      check_val("post_rst_idle0", 32'(ifc.out_port_write), 32'd0);
      @(negedge clk);
      check_val("post_rst_idle1", 32'(ifc.out_port_write), 32'd0);
      tick();

      // SDF: pair on both ports, output from port 0 two cycles later
      exp_q.push_back(9'h001);
      wr(1'b1, tok(1'b0, 8'd1), 1'b1, tok(1'b0, 8'd2));
      @(negedge clk);
      check_val("sdf_lat_early", 32'(ifc.out_port_write), 32'd0);
      @(negedge clk);
      check_val("sdf_lat", 32'(ifc.out_port_write), 32'd1);
      tick();
      exp_q.push_back(9'h002);
      wr(1'b1, tok(1'b0, 8'd1), 1'b1, tok(1'b0, 8'd2));
      drain("sdf_drain", 10);
      check_val("sdf_cyc0", 32'(cycles_done[7:0]), 32'd1);
      check_val("sdf_cyc1", 32'(cycles_done[15:8]), 32'd0);

      // CSDF: single-port consumption following the phase
      mode = 1'b1;
      tick();
      tick();
      exp_q.push_back(9'h105);
      wr(1'b1, tok(1'b1, 8'h05), 1'b0, '0);
      drain("csdf_drain0", 10);
      wr(1'b1, tok(1'b1, 8'h06), 1'b0, '0);
      repeat (4) tick();
      check_val("csdf_wait", 32'(exp_q.size()), 32'd0);
      exp_q.push_back(9'h107);
      exp_q.push_back(9'h106);
      wr(1'b0, '0, 1'b1, tok(1'b1, 8'h07));
      drain("csdf_drain1", 10);
      check_val("csdf_cyc1", 32'(cycles_done[15:8]), 32'd1);

      // Arbitration: preload both fluxes under back-pressure
      ifc.out_port_full = 1'b1;
      wr(1'b1, tok(1'b0, 8'h10), 1'b1, tok(1'b1, 8'h20));
      wr(1'b1, tok(1'b1, 8'h21), 1'b1, tok(1'b0, 8'h11));
      wr(1'b1, tok(1'b0, 8'h12), 1'b1, tok(1'b1, 8'h22));
      wr(1'b1, tok(1'b1, 8'h23), 1'b1, tok(1'b0, 8'h13));
      check_val("arb_in_full", 32'(ifc.in_port_full), 32'd0);
      check_val("arb_blocked", 32'(ifc.out_port_write), 32'd0);
      exp_q.push_back(9'h010); exp_q.push_back(9'h120);
      exp_q.push_back(9'h011); exp_q.push_back(9'h121);
      exp_q.push_back(9'h012); exp_q.push_back(9'h122);
      exp_q.push_back(9'h013); exp_q.push_back(9'h123);
      ifc.out_port_full = 1'b0;
      repeat (4) tick();
      ifc.out_port_full = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) ifc.out_port_full = 1'b0;
         @(negedge clk);
         check_val("arb_hold", 32'(ifc.out_port_write), 32'd0);
      end
      #1;
      check_val("arb_pending", 32'(exp_q.size()), 32'd4);
      drain("arb_drain", 20);
      check_val("arb_cyc0", 32'(cycles_done[7:0]), 32'd3);
      check_val("arb_cyc1", 32'(cycles_done[15:8]), 32'd3);

      // Full/drop: 5 writes to queue (0,0), 4 to (1,0), no firing
      ifc.out_port_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr(1'b1, tok(1'b0, 8'(8'h30 + i)), 1'b1, tok(1'b0, 8'(8'h40 + i)));
         if (i == 2) check_val("full_after3", 32'(ifc.in_port_full), 32'd0);
      end
      check_val("full_after4", 32'(ifc.in_port_full), 32'b0101);
      wr(1'b1, tok(1'b0, 8'h34), 1'b0, '0);
      check_val("full_after5", 32'(ifc.in_port_full), 32'b0101);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(tok(1'b0, 8'(8'h30 + i)));
         exp_q.push_back(tok(1'b0, 8'(8'h40 + i)));
      end
      ifc.out_port_full = 1'b0;
      drain("full_drain", 30);
      check_val("full_cleared", 32'(ifc.in_port_full), 32'd0);
      check_val("full_cyc0", 32'(cycles_done[7:0]), 32'd7);

      // Mode switch with ph[0]=1: idle cycle, phase cleared, tokens kept
      exp_q.push_back(9'h050);
      wr(1'b1, tok(1'b0, 8'h50), 1'b0, '0);
      drain("ms_drain0", 10);
      ifc.out_port_full = 1'b1;
      wr(1'b1, tok(1'b0, 8'h51), 1'b1, tok(1'b0, 8'h52));
      mode = 1'b0;
      ifc.out_port_full = 1'b0;
      exp_q.push_back(9'h051);
      @(negedge clk);
      @(negedge clk);
      check_val("ms_idle", 32'(ifc.out_port_write), 32'd0);
      @(negedge clk);
      check_val("ms_fire", 32'(ifc.out_port_write), 32'd1);
      tick();
      exp_q.push_back(9'h054);
      wr(1'b1, tok(1'b0, 8'h53), 1'b1, tok(1'b0, 8'h54));
      drain("ms_drain1", 10);
      check_val("ms_cyc0", 32'(cycles_done[7:0]), 32'd8);
      check_val("ms_cyc1", 32'(cycles_done[15:8]), 32'd3);

      // Reset mid-operation discards queued tokens
      ifc.out_port_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr(1'b1, tok(1'b0, 8'(8'h60 + i)), 1'b0, '0);
      end
      check_val("pre_rst_full", 32'(ifc.in_port_full), 32'b0001);
      rst = 1'b0;
      tick();
      check_val("mid_rst_full", 32'(ifc.in_port_full), 32'd0);
      check_val("mid_rst_cycles", 32'(cycles_done), 32'd0);
      check_val("mid_rst_data", 32'(ifc.out_port_dataout), 32'd0);
      rst = 1'b1;
      ifc.out_port_full = 1'b0;
      repeat (6) tick();
      check_val("mid_rst_sb", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ms_pick_actor.md
# ms_pick_actor

Parametrised multi-stream PICK actor for the tagged dataflow fabric. It accepts tagged tokens on PORTS input ports and queues them per port and per flux (stream). It fires one flux per cycle, picking tokens according to a per-flux phase counter. It supports both SDF and CSDF consumption at run time, which makes it the generalised successor of the fixed 2-port/2-flux SDF and CSDF pick wrappers.

## Interface
Parameters:
- DATA_WIDTH, 8, payload bits per token
- FLUX, 2, number of independent streams (≥2)
- PORTS, 2, number of input ports (≥2)
- DEPTH, 4, slots per port/flux queue (≥2)
- TAG_WIDTH, $clog2(FLUX), tag bits at MSBs of every token
- WIDTH, DATA_WIDTH+TAG_WIDTH, token width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset (sampled on clk edge when 0)
- in_port_write  in  PORTS  per-port write strobe
- in_port_datain  in  PORTS*WIDTH  port p token at bits [p*WIDTH +: WIDTH], tag = top TAG_WIDTH bits
- in_port_full  out  PORTS*FLUX  bit p*FLUX+f = queue (p,f) full
- mode  in  1  0 = SDF, 1 = CSDF
- out_port_full  in  1  downstream back-pressure
- out_port_write  out  1  one-cycle token-valid strobe
- out_port_dataout  out  WIDTH  {tag, payload} of picked token
- cycles_done  out  FLUX*8  per-flux completed-cycle counters, 8 bits each, wrapping

## Operation
- Write routing: on in_port_write[p], token goes to queue (p, tag). Write to a full queue is dropped with no other effect. Tag ≥ FLUX is dropped.
- Each flux f has a phase counter ph[f] in 0..PORTS-1.
- SDF eligibility: every queue (p,f), p = 0..PORTS-1, is non-empty. Firing pops one token from every port, outputs the token popped from port ph[f], then increments ph[f].
- CSDF eligibility: queue (ph[f],f) is non-empty. Firing pops only that token, outputs it, then increments ph[f].
- Wrap: when ph[f] wraps from PORTS-1 to 0, cycles_done[f] increments, wrapping 255→0.
- Arbitration:
  - At most one firing per cycle.
  - Round-robin over eligible fluxes, starting at (last fired flux + 1) mod FLUX. After reset the pointer points at flux 0.
- No firing while out_port_full=1. In that case queues, phases and the arbiter pointer hold.
- Mode change: a change of mode, detected against a registered copy of mode, clears all ph[f] to 0 in that cycle. No firing happens in that cycle. Queue contents are kept.
- Output tag equals the fired flux index. The payload is passed unchanged.

## Timing
- Reset (rst=0 at an edge) clears:
  - all queues to empty, so in_port_full = 0
  - ph, arbiter pointer and cycles_done to 0
  - out_port_write = 0 and out_port_dataout = 0
- Reset mid-operation discards all queued tokens. There is no output in the cycle after reset.
- in_port_full is registered and reflects the count after the previous edge.
- Write-to-output latency:
  - A token written at edge t is eligible in cycle t+1.
  - If it fires, out_port_write=1 with its data after edge t+1, i.e. during cycle t+2.
- out_port_write is a single-cycle pulse per firing. Back-to-back firings give consecutive pulses.
- Simultaneous write and pop on the same queue:
  - Allowed if the queue is not full; the count is unchanged.
  - If the queue is full, the write is dropped even when a pop occurs in the same cycle.
- out_port_full is sampled combinationally in the firing cycle. A pulse already issued is not retracted.
- Queues are circular with independent read/write pointers modulo DEPTH. The count range is 0..DEPTH.

## Structure
- Package ms_pkg holds:
  - tag-width function (minimum 1)
  - mode constants MODE_SDF=0, MODE_CSDF=1
  - cycle-counter width constant CYC_W=8
- Sub-module ms_fifo: single queue of WIDTH×DEPTH with push, pop, empty, full and head outputs. It is instantiated PORTS*FLUX times via generate.
- The top level holds:
  - routing decode
  - eligibility logic
  - round-robin arbiter
  - phase and cycle counters
  - output register

## Test plan
- Reset: hold rst=0 for 3 cycles with writes active -> all outputs 0, in_port_full=0, no out_port_write for 2 cycles after release.
- SDF, PORTS=2, FLUX=2: write {0,8'd1} on port 0 and {0,8'd2} on port 1 at the same edge -> one output 0x001, two cycles later. Repeating the pair -> 0x002 and cycles_done[0]=1.
- CSDF, same config: write {1,8'd5} on port 0 only -> output 0x105. A further port-0 token for flux 1 does not fire until a flux-1 token is written on port 1 -> 0x1xx, then cycles_done[1]=1.
- Arbitration: both fluxes eligible every cycle -> outputs alternate tag 0,1,0,1. Holding out_port_full=1 for 3 cycles -> no pulses, sequence resumes unchanged.
- Full/drop, DEPTH=4: 5 writes to queue (0,0) with no firing -> in_port_full[0]=1 after the 4th write, 5th token dropped. Draining yields exactly 4 outputs.
- Mode switch: CSDF with ph[0]=1, then toggle mode -> one idle cycle, ph[0]=0, queued tokens preserved and consumed under SDF rules.
